kmeans_centroid_divider: RTL and testbench
==========================================

Name: kmeans_centroid_divider

Overview:
Sequential centroid-update stage that sits directly downstream of the k-means FSM's per-cluster accumulators. On a start pulse it walks clusters 0..K-1 and reads each cluster's sums and count through a select port. It divides the three coordinate sums by the count with shared-divisor restoring dividers and writes one centroid per cluster to the centroid registers. It replaces the combinational sum/cnt divide. Empty clusters are re-seeded from a constant table.

Parameters:
K, 7, number of clusters
SUM_W, 16, width of the coordinate sum inputs
CNT_W, 6, width of the point-count input
COORD_W, 8, width of the centroid coordinates

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request to begin an update pass
sel_k  out  3  cluster index being fetched; the parent muxes sum_*/cnt from it combinationally
sum_x  in  SUM_W  x sum of cluster sel_k
sum_y  in  SUM_W  y sum of cluster sel_k
sum_z  in  SUM_W  z sum of cluster sel_k
cnt  in  CNT_W  point count of cluster sel_k
c_we  out  1  centroid write strobe, one cycle per cluster
c_idx  out  3  cluster index being written
cx  out  COORD_W  new x centroid
cy  out  COORD_W  new y centroid
cz  out  COORD_W  new z centroid
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the pass completes

Behaviour:
- Reset: asynchronous, active-high. FSM goes to IDLE. sel_k, c_idx, cx, cy, cz = 0; c_we = 0; busy = 0; done = 0.
- Reset mid-operation aborts the pass immediately. No further c_we is issued. There is no partial-pass resume.
- States: IDLE, LOAD, DIV, WRITE, DONE.
- IDLE: if start = 1, go to LOAD with k = 0. Otherwise stay.
- start is ignored in every state other than IDLE.
- sel_k = k at all times outside IDLE.
- LOAD, 1 cycle: register sum_x/y/z and cnt.
  - If cnt = 0, load the reseed triple for k into the quotient registers and go to WRITE.
  - Otherwise go to DIV.
- DIV, SUM_W cycles: three restoring dividers run in lock-step, one quotient bit per cycle, MSB first, sharing divisor cnt. Then go to WRITE.
- Quotient: full SUM_W bits wide. If the quotient exceeds 2^COORD_W - 1, the output saturates to 2^COORD_W - 1.
- WRITE, 1 cycle: c_we = 1, c_idx = k, cx/cy/cz = results.
  - If k = K-1, go to DONE.
  - Otherwise k <= k+1 and go to LOAD.
- DONE, 1 cycle: done = 1, busy = 0 next cycle, go to IDLE.
- cx/cy/cz/c_idx hold their last values when c_we = 0.
- Latency per cluster: 1 (LOAD) + SUM_W (DIV) + 1 (WRITE) cycles for a non-empty cluster; 2 cycles for an empty one.
- Latency per pass: all clusters non-empty gives start-accept edge to done pulse = K*(SUM_W+2)+1 = 127 cycles at defaults.
- Writes always occur in ascending c_idx order, exactly K per pass.

Optional Feature:
- Macro: KMEANS_ROUND_EN.
- Defined: the dividend becomes sum + (cnt >> 1), widened to SUM_W+1 bits. DIV then lasts SUM_W+1 cycles, giving round-half-up averages. Saturation is unchanged.
- Undefined: truncating division, SUM_W DIV cycles.

Decomposition:
- Package kmeans_pkg:
  - constants K, SUM_W, CNT_W, COORD_W
  - FSM state encoding
  - reseed table, indexed 0..6: (10,10,10), (50,50,50), (90,20,70), (20,80,30), (70,70,20), (40,10,90), (120,5,90)
- Sub-module kmeans_restoring_div: one-bit-per-cycle restoring divider with load/step/valid. Instantiated three times, divisor shared.

Test Plan:
- All K clusters have cnt = 3 and sum_x/y/z = 300/150/30 -> 7 writes in order c_idx 0..6, each cx=100, cy=50, cz=10; done exactly 127 cycles after start; busy low afterwards.
- Cluster 2 has cnt = 0 and the others are as above -> c_idx=2 writes (90,20,70); the pass completes 16 cycles earlier (done at 111).
- sum_x=65535, cnt=1 -> cx saturates to 255. sum_x=254, cnt=2 -> cx=127.
- sum_x=10, cnt=4 -> cx=2 without KMEANS_ROUND_EN; cx=3 with KMEANS_ROUND_EN, and DIV lasts 17 cycles.
- Pulse start again while busy, during DIV of cluster 3 -> ignored, still exactly 7 writes and a single done.
- Assert rst during DIV of cluster 4 -> all outputs 0 immediately, no c_we for clusters 4..6. A new start afterwards runs a clean full pass.

Source files
------------

// File: rtl/kmeans_pkg.sv
// Shared constants, FSM encoding and helpers for the k-means centroid divider.
// KMEANS_ROUND_EN widens the dividend by one bit for round-half-up averaging.
package kmeans_pkg;

  localparam int unsigned K       = 7;
  localparam int unsigned SUM_W   = 16;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned COORD_W = 8;

`ifdef KMEANS_ROUND_EN
  localparam int unsigned DIV_W = SUM_W + 1;
`else
  localparam int unsigned DIV_W = SUM_W;
`endif

  typedef enum logic [2:0] {StIdle, StLoad, StDiv, StWrite, StDone} state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } coord_t;

  // Fixed seed positions used when a cluster ends a pass with no points.
  function automatic coord_t reseed(input logic [2:0] k);
    case (k)
      3'd0:    reseed = {8'd10,  8'd10, 8'd10};
      3'd1:    reseed = {8'd50,  8'd50, 8'd50};
      3'd2:    reseed = {8'd90,  8'd20, 8'd70};
      3'd3:    reseed = {8'd20,  8'd80, 8'd30};
      3'd4:    reseed = {8'd70,  8'd70, 8'd20};
      3'd5:    reseed = {8'd40,  8'd10, 8'd90};
      3'd6:    reseed = {8'd120, 8'd5,  8'd90};
      default: reseed = '0;
    endcase
  endfunction

  function automatic logic [COORD_W-1:0] saturate(input logic [DIV_W-1:0] q);
    if (|q[DIV_W-1:COORD_W]) saturate = {COORD_W{1'b1}};
    else                     saturate = q[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/kmeans_restoring_div.sv
// One-quotient-bit-per-cycle restoring divider, MSB first.
// The dividend register doubles as the quotient register as bits shift through.
module kmeans_restoring_div #(
  parameter int unsigned DVD_W = 16,
  parameter int unsigned DVS_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic             last,
  output logic             valid
);

  localparam int unsigned STEP_W = $clog2(DVD_W + 1);

  logic [DVD_W-1:0]  q_q;
  logic [DVS_W-1:0]  rem_q;
  logic [STEP_W-1:0] n_q;
  logic [DVS_W:0]    shifted;
  logic              ge;

  // Remainder stays below the divisor, so DVS_W bits hold it between steps.
  assign shifted  = {rem_q, q_q[DVD_W-1]};
  assign ge       = shifted >= {1'b0, divisor};
  assign valid    = n_q == STEP_W'(DVD_W);
  assign last     = step && (n_q == STEP_W'(DVD_W - 1));
  assign quotient = q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= '0;
      rem_q <= '0;
      n_q   <= '0;
    end else if (load) begin
      q_q   <= dividend;
      rem_q <= '0;
      n_q   <= '0;
    end else if (step && !valid) begin
      q_q   <= {q_q[DVD_W-2:0], ge};
      rem_q <= ge ? DVS_W'(shifted - {1'b0, divisor}) : shifted[DVS_W-1:0];
      n_q   <= n_q + 1'b1;
    end
  end

endmodule

// File: rtl/kmeans_centroid_divider.sv
// Sequential centroid update: walks all clusters, divides sums by count, writes centroids.
// KMEANS_ROUND_EN selects round-half-up division (one extra DIV cycle per cluster).
module kmeans_centroid_divider
  import kmeans_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [2:0]         sel_k,
  input  logic [SUM_W-1:0]   sum_x,
  input  logic [SUM_W-1:0]   sum_y,
  input  logic [SUM_W-1:0]   sum_z,
  input  logic [CNT_W-1:0]   cnt,
  output logic               c_we,
  output logic [2:0]         c_idx,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic [COORD_W-1:0] cz,
  output logic               busy,
  output logic               done
);

  state_t           state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [CNT_W-1:0] cnt_q;
  logic [DIV_W-1:0] dvd_x, dvd_y, dvd_z;
  logic [DIV_W-1:0] q_x, q_y, q_z;
  logic             last_x, last_y, last_z;
  logic             valid_x, valid_y, valid_z;
  logic             div_last, div_valid;
  coord_t           seed;

`ifdef KMEANS_ROUND_EN
  logic [DIV_W-1:0] half;
  assign half  = DIV_W'(cnt >> 1);
  assign dvd_x = DIV_W'(sum_x) + half;
  assign dvd_y = DIV_W'(sum_y) + half;
  assign dvd_z = DIV_W'(sum_z) + half;
`else
  assign dvd_x = sum_x;
  assign dvd_y = sum_y;
  assign dvd_z = sum_z;
`endif

  assign sel_k     = k_q;
  assign seed      = reseed(k_q);
  assign div_last  = last_x & last_y & last_z;
  assign div_valid = valid_x & valid_y & valid_z;

  kmeans_restoring_div #(.DVD_W(DIV_W), .DVS_W(CNT_W)) u_div_x (
    .clk(clk), .rst(rst), .load(state_q == StLoad), .step(state_q == StDiv),
    .dividend(dvd_x), .divisor(cnt_q), .quotient(q_x), .last(last_x), .valid(valid_x)
  );
  kmeans_restoring_div #(.DVD_W(DIV_W), .DVS_W(CNT_W)) u_div_y (
    .clk(clk), .rst(rst), .load(state_q == StLoad), .step(state_q == StDiv),
    .dividend(dvd_y), .divisor(cnt_q), .quotient(q_y), .last(last_y), .valid(valid_y)
  );
  kmeans_restoring_div #(.DVD_W(DIV_W), .DVS_W(CNT_W)) u_div_z (
    .clk(clk), .rst(rst), .load(state_q == StLoad), .step(state_q == StDiv),
    .dividend(dvd_z), .divisor(cnt_q), .quotient(q_z), .last(last_z), .valid(valid_z)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          k_d     = '0;
        end
      end
      StLoad:  state_d = (cnt == '0) ? StWrite : StDiv;
      StDiv:   if (div_last) state_d = StWrite;
      StWrite: begin
        if (k_q == 3'(K - 1)) begin
          state_d = StDone;
        end else begin
          k_d     = k_q + 3'd1;
          state_d = StLoad;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (state_q == StLoad) cnt_q <= cnt;
    end
  end

  // An empty cluster reloads the dividers without stepping, so valid is low in WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_we  <= 1'b0;
      c_idx <= '0;
      cx    <= '0;
      cy    <= '0;
      cz    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      c_we <= state_q == StWrite;
      done <= state_q == StDone;
      if (state_q == StIdle && start) busy <= 1'b1;
      else if (state_q == StDone)     busy <= 1'b0;
      if (state_q == StWrite) begin
        c_idx <= k_q;
        if (div_valid) begin
          cx <= saturate(q_x);
          cy <= saturate(q_y);
          cz <= saturate(q_z);
        end else begin
          cx <= seed.x;
          cy <= seed.y;
          cz <= seed.z;
        end
      end
    end
  end

endmodule

// File: tb/tb_kmeans_centroid_divider.sv
// Scoreboard bench for kmeans_centroid_divider: a behavioural parent supplies per-cluster
// sums, expected centroid writes are queued at start and popped on each c_we.
module tb_kmeans_centroid_divider;

`ifdef KMEANS_ROUND_EN
  localparam int DIVC = 17;
`else
  localparam int DIVC = 16;
`endif
  localparam int NK = 7;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] sel_k, c_idx;
  logic [15:0] sum_x, sum_y, sum_z;
  logic [5:0] cnt;
  logic       c_we, busy, done;
  logic [7:0] cx, cy, cz;

  int sx[8], sy[8], sz[8], cn[8];
  int seed_x[7] = '{10, 50, 90, 20, 70, 40, 120};
  int seed_y[7] = '{10, 50, 20, 80, 70, 10, 5};
  int seed_z[7] = '{10, 50, 70, 30, 20, 90, 90};

  typedef struct {int idx; int x; int y; int z;} wr_t;
  wr_t sb[$];

  int checks = 0, errors = 0, writes = 0, dones = 0;
  int lat, w0, d0;

  assign sum_x = 16'(sx[sel_k]);
  assign sum_y = 16'(sy[sel_k]);
  assign sum_z = 16'(sz[sel_k]);
  assign cnt   = 6'(cn[sel_k]);

  always #5 clk = ~clk;

  kmeans_centroid_divider dut (
    .clk(clk), .rst(rst), .start(start), .sel_k(sel_k),
    .sum_x(sum_x), .sum_y(sum_y), .sum_z(sum_z), .cnt(cnt),
    .c_we(c_we), .c_idx(c_idx), .cx(cx), .cy(cy), .cz(cz),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int avg(input int s, input int c, input int seed);
    int q;
    if (c == 0) return seed;
`ifdef KMEANS_ROUND_EN
    q = (s + c / 2) / c;
`else
    q = s / c;
`endif
    return (q > 255) ? 255 : q;
  endfunction

  function automatic int exp_lat();
    int l = 1;
    for (int k = 0; k < NK; k++) l += (cn[k] == 0) ? 2 : DIVC + 2;
    return l;
  endfunction

  task automatic push_pass();
    for (int k = 0; k < NK; k++)
      sb.push_back('{k, avg(sx[k], cn[k], seed_x[k]), avg(sy[k], cn[k], seed_y[k]),
                     avg(sz[k], cn[k], seed_z[k])});
  endtask

  // Starts a pass and counts cycles from the accept edge to done; extra_at pulses start again.
  task automatic run_pass(input int extra_at, output int cycles);
    push_pass();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 1000) begin
      @(posedge clk); #1;
      cycles++;
      start = (cycles == extra_at);
    end
    start = 1'b0;
    if (cycles >= 1000) check("done_timeout", 0, 1);
  endtask

  task automatic fill(input int c);
    for (int k = 0; k < 8; k++) begin
      sx[k] = 300; sy[k] = 150; sz[k] = 30; cn[k] = c;
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (done) dones++;
      if (c_we) begin
        writes++;
        if (sb.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = sb.pop_front();
          check("c_idx", c_idx, e.idx);
          check("cx", cx, e.x);
          check("cy", cy, e.y);
          check("cz", cz, e.z);
        end
      end
    end
  end

  task automatic settle_and_count(input string tag, input int exp_writes, input int exp_dones);
    repeat (40) @(posedge clk);
    #1;
    check({tag, "_writes"}, writes - w0, exp_writes);
    check({tag, "_dones"}, dones - d0, exp_dones);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    fill(3);
    #12;
    check("rst_c_we", c_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sel_k", sel_k, 0);
    check("rst_c_idx", c_idx, 0);
    check("rst_cxyz", {cx, cy, cz}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Uniform clusters.
    w0 = writes; d0 = dones;
    run_pass(-1, lat);
    check("lat_full", lat, exp_lat());
    check("busy_at_done", busy, 0);
    settle_and_count("full", 7, 1);

    // Empty cluster 2 takes its seed and shortens the pass.
    cn[2] = 0;
    w0 = writes; d0 = dones;
    run_pass(-1, lat);
    check("lat_empty", lat, exp_lat());
    settle_and_count("empty", 7, 1);

    // Saturation, exact halving and rounding.
    cn[2] = 3;
    sx[0] = 65535; cn[0] = 1;
    sx[1] = 254;   cn[1] = 2;
    sx[3] = 10;    cn[3] = 4;
    w0 = writes; d0 = dones;
    run_pass(-1, lat);
    check("lat_mixed", lat, exp_lat());
    settle_and_count("mixed", 7, 1);

    // Second start during DIV of cluster 3 must be ignored.
    fill(3);
    w0 = writes; d0 = dones;
    run_pass(3 * (DIVC + 2) + 5, lat);
    check("lat_restart", lat, exp_lat());
    settle_and_count("restart", 7, 1);

    // Reset during DIV of cluster 4 aborts the pass.
    w0 = writes; d0 = dones;
    push_pass();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4 * (DIVC + 2) + 5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("abort_c_we", c_we, 0);
    check("abort_busy", busy, 0);
    check("abort_sel_k", sel_k, 0);
    check("abort_c_idx", c_idx, 0);
    check("abort_cxyz", {cx, cy, cz}, 0);
    check("abort_pending", sb.size(), 3);
    check("abort_writes", writes - w0, 4);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    w0 = writes;
    settle_and_count("after_abort", 0, 0);

    // Clean pass after the abort.
    w0 = writes; d0 = dones;
    run_pass(-1, lat);
    check("lat_after_abort", lat, exp_lat());
    settle_and_count("clean", 7, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
